// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP parameter loader: word-format defaults,
// frame opcodes and the loader state encoding.
package mlp_pkg;

    localparam int DEFAULT_FP_TOTAL_BITS = 16;
    localparam int DEFAULT_FP_FRAC_BITS  = 8;

    localparam logic [7:0] OP_W = 8'h01;
    localparam logic [7:0] OP_B = 8'h02;
    localparam logic [7:0] OP_X = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CKSUM,
        FIRE,
        BUSY
    } ld_state_t;

    // Payload length in words of a frame with the given opcode.
    function automatic int frame_words(logic [7:0] op, int nf, int nc);
        case (op)
            OP_W:    return nf * nc;
            OP_B:    return nc;
            OP_X:    return nf;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/mlp_param_loader_if.sv
// Byte-stream valid/ready channel feeding the parameter loader.
interface mlp_param_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/le_word_assembler.sv
// Little-endian byte-to-word assembler: collects BPW bytes LSB first; the full word
// is presented combinationally together with word_valid on the last byte.
module le_word_assembler #(
    parameter int BPW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic [8*BPW-1:0]   word,
    output logic               word_valid
);
    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;

    assign word_valid = byte_valid && (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            cnt <= word_valid ? '0 : cnt + 1'b1;
        end
    end

    generate
        if (BPW == 1) begin : g_single
            assign word = byte_data;
        end else begin : g_multi
            logic [8*(BPW-1)-1:0] sh;

            // Newest byte enters at the top so the first byte ends up as the LSB.
            always_ff @(posedge clk) begin
                if (byte_valid) begin
                    sh <= (8*(BPW-1))'({byte_data, sh} >> 8);
                end
            end

            assign word = {byte_data, sh};
        end
    endgenerate

endmodule

// File: rtl/mlp_param_loader.sv
// Command-framed byte-stream loader for the weight, bias and input operands of an MLP layer.
// Optional feature macro: PARAM_CKSUM_EN (trailing XOR checksum byte per frame, sticky cksum_err).
module mlp_param_loader
    import mlp_pkg::*;
#(
    parameter int NUM_FEATURES  = 4,
    parameter int NUM_CLASSES   = 4,
    parameter int FP_TOTAL_BITS = DEFAULT_FP_TOTAL_BITS,
    parameter int FP_FRAC_BITS  = DEFAULT_FP_FRAC_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    mlp_param_loader_if.slave               in_bus,
    input  logic                            done,
    output logic                            start,
    output logic signed [FP_TOTAL_BITS-1:0] weights [NUM_FEATURES][NUM_CLASSES],
    output logic signed [FP_TOTAL_BITS-1:0] bias [NUM_CLASSES],
    output logic signed [FP_TOTAL_BITS-1:0] x [NUM_FEATURES],
    output logic                            busy,
    output logic                            err_cmd
`ifdef PARAM_CKSUM_EN
    ,
    output logic                            cksum_err
`endif
);
    localparam int BPW = FP_TOTAL_BITS / 8;
    localparam int NW  = NUM_FEATURES * NUM_CLASSES;
    localparam int CW  = $clog2(NW + 1);
    // A word format that is not whole bytes, or has no integer part, never accepts a byte.
    localparam bit CFG_OK = (FP_TOTAL_BITS % 8 == 0) && (FP_FRAC_BITS < FP_TOTAL_BITS);

    ld_state_t               state, state_nx;
    logic [7:0]              op;
    logic [CW-1:0]           wcnt;
    logic [CW-1:0]           nwords;
    logic                    done_q;
    logic                    accept, op_valid, op_accept, byte_ld;
    logic                    word_valid, last_word;
    logic [FP_TOTAL_BITS-1:0] word;
`ifdef PARAM_CKSUM_EN
    logic [7:0]              cks;
    logic                    cks_ok;
`endif

    assign in_bus.in_ready = CFG_OK && (state == IDLE || state == LOAD || state == CKSUM);
    assign accept    = in_bus.in_valid && in_bus.in_ready;
    assign op_valid  = in_bus.in_data inside {OP_W, OP_B, OP_X};
    assign op_accept = (state == IDLE) && accept && op_valid;
    assign byte_ld   = (state == LOAD) && accept;
    assign nwords    = CW'(frame_words(op, NUM_FEATURES, NUM_CLASSES));
    assign last_word = word_valid && (wcnt == nwords - 1'b1);
    assign start     = (state == FIRE);
    assign busy      = (state == FIRE) || (state == BUSY);
`ifdef PARAM_CKSUM_EN
    assign cks_ok    = (in_bus.in_data == cks);
`endif

    le_word_assembler #(.BPW(BPW)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (op_accept),
        .byte_valid (byte_ld),
        .byte_data  (in_bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (op_accept) state_nx = LOAD;
            LOAD: begin
                if (last_word) begin
`ifdef PARAM_CKSUM_EN
                    state_nx = CKSUM;
`else
                    state_nx = (op == OP_X) ? FIRE : IDLE;
`endif
                end
            end
`ifdef PARAM_CKSUM_EN
            CKSUM: if (accept) state_nx = (op == OP_X && cks_ok) ? FIRE : IDLE;
`endif
            FIRE: state_nx = BUSY;
            // done_q tracks done every cycle, so a level left high from the last run is not a rise.
            BUSY: if (done && !done_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op      <= '0;
            wcnt    <= '0;
            done_q  <= 1'b0;
            err_cmd <= 1'b0;
`ifdef PARAM_CKSUM_EN
            cks       <= '0;
            cksum_err <= 1'b0;
`endif
            for (int r = 0; r < NUM_FEATURES; r++)
                for (int c = 0; c < NUM_CLASSES; c++)
                    weights[r][c] <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) bias[c] <= '0;
            for (int k = 0; k < NUM_FEATURES; k++) x[k] <= '0;
        end else begin
            done_q  <= done;
            err_cmd <= (state == IDLE) && accept && !op_valid;
            if (op_accept) begin
                op   <= in_bus.in_data;
                wcnt <= '0;
            end else if (word_valid) begin
                wcnt <= wcnt + 1'b1;
            end
`ifdef PARAM_CKSUM_EN
            if (op_accept)   cks <= in_bus.in_data;
            else if (byte_ld) cks <= cks ^ in_bus.in_data;
            if (state == CKSUM && accept && !cks_ok) cksum_err <= 1'b1;
`endif
            for (int r = 0; r < NUM_FEATURES; r++)
                for (int c = 0; c < NUM_CLASSES; c++)
                    if (word_valid && op == OP_W && wcnt == CW'(r * NUM_CLASSES + c))
                        weights[r][c] <= word;
            for (int c = 0; c < NUM_CLASSES; c++)
                if (word_valid && op == OP_B && wcnt == CW'(c)) bias[c] <= word;
            for (int k = 0; k < NUM_FEATURES; k++)
                if (word_valid && op == OP_X && wcnt == CW'(k)) x[k] <= word;
        end
    end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Directed bench for mlp_param_loader: frames, launch handshake, bad opcode, mid-frame reset
// and, with PARAM_CKSUM_EN, checksum rejection.
module tb_mlp_param_loader;
    import mlp_pkg::*;

    localparam int NF = 4;
    localparam int NC = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done = 1'b0;
    logic start, busy, err_cmd;
    logic signed [W-1:0] weights [NF][NC];
    logic signed [W-1:0] bias [NC];
    logic signed [W-1:0] x [NF];
`ifdef PARAM_CKSUM_EN
    logic cksum_err;
`endif

    int total = 0;
    int bad = 0;
    int ready_waits = 0;
    logic [7:0] pl [$];

    mlp_param_loader_if bus ();

    mlp_param_loader #(
        .NUM_FEATURES  (NF),
        .NUM_CLASSES   (NC),
        .FP_TOTAL_BITS (W),
        .FP_FRAC_BITS  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_bus  (bus),
        .done    (done),
        .start   (start),
        .weights (weights),
        .bias    (bias),
        .x       (x),
        .busy    (busy),
        .err_cmd (err_cmd)
`ifdef PARAM_CKSUM_EN
        ,
        .cksum_err (cksum_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkl(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n > 0) ready_waits++;
        if (!bus.in_ready) begin
            total++;
            bad++;
            $error("FAIL ready_timeout observed=%b expected=1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op);
        logic [7:0] c;
        c = op;
        send_byte(op);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            c = c ^ pl[i];
        end
`ifdef PARAM_CKSUM_EN
        send_byte(c);
`endif
    endtask

    // Reference layer: out[j] = (sum x*w + (b<<<8) + 128) >>> 8
    function automatic longint layer_out(int j);
        longint acc = 0;
        for (int k = 0; k < NF; k++) acc += longint'(x[k]) * longint'(weights[k][j]);
        acc += longint'(bias[j]) <<< 8;
        acc += 128;
        return acc >>> 8;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        #12;
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_cmd, 1'b0);
        chkw("rst_w12", weights[1][2], 16'h0000);
        chkw("rst_b0", bias[0], 16'h0000);
        chkw("rst_x3", x[3], 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", bus.in_ready, 1'b1);

        // Weights frame: word i = i*0x0101
        pl.delete();
        for (int i = 0; i < 16; i++) begin
            pl.push_back(8'(i));
            pl.push_back(8'(i));
        end
        send_frame(8'h01);
        chkw("w00", weights[0][0], 16'h0000);
        chkw("w12", weights[1][2], 16'h0606);
        chkw("w33", weights[3][3], 16'h0F0F);
        chk("w_start", start, 1'b0);
        chk("w_busy", busy, 1'b0);
        chk("w_ready", bus.in_ready, 1'b1);

        // Bias frame, ready never drops
        ready_waits = 0;
        pl = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'hFF};
        send_frame(8'h02);
        chkw("b0", bias[0], 16'h0080);
        chkw("b1", bias[1], 16'hFF00);
        chkw("b2", bias[2], 16'h0100);
        chkw("b3", bias[3], 16'hFFFF);
        chkw("b_ready_waits", 16'(ready_waits), 16'd0);

        // X frame with a stale high done from a previous run
        done = 1'b1;
        pl = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h03};
        send_frame(8'h03);
        chk("x_start", start, 1'b1);
        chk("x_busy", busy, 1'b1);
        chk("x_ready", bus.in_ready, 1'b0);
        chkw("x0", x[0], 16'h0080);
        chkw("x1", x[1], 16'hFF00);
        chkw("x2", x[2], 16'h0000);
        chkw("x3", x[3], 16'h0300);
        chkl("out0", layer_out(0), 64'sd8352);
        chkl("out1", layer_out(1), 64'sd8611);
        chkl("out2", layer_out(2), 64'sd9765);
        chkl("out3", layer_out(3), 64'sd10151);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7E;
        @(posedge clk); #1;
        chk("x_start_pulse", start, 1'b0);
        chk("x_busy_hold", busy, 1'b1);
        chk("x_ready_busy", bus.in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("stale_done_busy", busy, 1'b1);
        chk("busy_no_err", err_cmd, 1'b0);
        bus.in_valid = 1'b0;
        done = 1'b0;
        @(posedge clk); #1;
        chk("done_low_busy", busy, 1'b1);
        done = 1'b1;
        @(posedge clk); #1;
        chk("done_rise_busy", busy, 1'b0);
        chk("done_rise_ready", bus.in_ready, 1'b1);
        done = 1'b0;

        // Unknown opcode, then a bias frame
        send_byte(8'h7E);
        chk("bad_op_err", err_cmd, 1'b1);
        chk("bad_op_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("bad_op_err_clear", err_cmd, 1'b0);
        pl = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        send_frame(8'h02);
        chkw("b2_0", bias[0], 16'h0001);
        chkw("b2_3", bias[3], 16'h0004);
        chkw("w12_hold", weights[1][2], 16'h0606);

        // Reset in the middle of a weights frame
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chkw("mid_w00", weights[0][0], 16'h2211);
        #2;
        reset = 1'b1;
        #1;
        chkw("mrst_w00", weights[0][0], 16'h0000);
        chkw("mrst_w12", weights[1][2], 16'h0000);
        chkw("mrst_b3", bias[3], 16'h0000);
        chkw("mrst_x3", x[3], 16'h0000);
        chk("mrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mrst_ready", bus.in_ready, 1'b1);
        pl.delete();
        for (int i = 0; i < 16; i++) begin
            pl.push_back(8'(i + 1));
            pl.push_back(8'h00);
        end
        send_frame(8'h01);
        chkw("fresh_w00", weights[0][0], 16'h0001);
        chkw("fresh_w12", weights[1][2], 16'h0007);
        chkw("fresh_w33", weights[3][3], 16'h0010);

`ifdef PARAM_CKSUM_EN
        // Wrong checksum on an x frame (correct XOR is 0x7F)
        pl = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h03};
        send_byte(8'h03);
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(8'h00);
        chk("ck_bad_start", start, 1'b0);
        chk("ck_bad_busy", busy, 1'b0);
        chk("ck_bad_ready", bus.in_ready, 1'b1);
        chk("ck_bad_err", cksum_err, 1'b1);
        chkw("ck_bad_x3", x[3], 16'h0300);
        @(posedge clk); #1;
        chk("ck_sticky", cksum_err, 1'b1);
        chk("ck_no_start", start, 1'b0);
        send_frame(8'h03);
        chk("ck_good_start", start, 1'b1);
        chk("ck_good_sticky", cksum_err, 1'b1);
        @(posedge clk); #1;
        done = 1'b1;
        @(posedge clk); #1;
        chk("ck_done_busy", busy, 1'b0);
        done = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
